button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Sits directly downstream of the line debouncer. Consumes its clean, clk-synchronous level and classifies operator button activity into single-cycle command pulses.
- Pulse meanings: short press = start ROM read; long press = abort/clear; double press = mode select.
- Also exports the registered button level for status LEDs.

Parameters:
- ACTIVE_LEVEL, 1, logic level of line that means "pressed".
- LONG_PRESS_CYCLES, 1000, hold length (clk cycles) that classifies a press as long. Legal range ≥ 2.
- DOUBLE_GAP_CYCLES, 200, maximum released gap (clk cycles) between two presses that still forms a double press. Legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- line  input  1  debounced button level, already synchronous to clk.
- pressed  output  1  registered (line == ACTIVE_LEVEL).
- short_press  output  1  one-cycle pulse.
- long_press  output  1  one-cycle pulse.
- double_press  output  1  one-cycle pulse.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - While reset is high: state=IDLE, 32-bit counter cnt=0, all outputs 0.
  - Reset mid-operation discards any pending classification; no pulse is emitted afterwards.
- act = (line == ACTIVE_LEVEL), sampled each rising edge. pressed <= act (1-cycle latency).
- All pulse outputs are registered and default to 0 every cycle. At most one pulse is high in any cycle.
- cnt is cleared to 0 on every state transition.
- FSM states: IDLE, PRESS1, GAP, PRESS2, HOLD.
- IDLE: act -> PRESS1.
- PRESS1:
  - !act -> GAP.
  - act and cnt == LONG_PRESS_CYCLES-1 -> long_press<=1, go to HOLD.
  - Otherwise cnt+1.
  - Result: long_press is high during the cycle following the L-th edge after the detecting edge (L = LONG_PRESS_CYCLES).
- GAP:
  - act -> PRESS2. Press wins over expiry on the same edge.
  - !act and cnt == DOUBLE_GAP_CYCLES-1 -> short_press<=1, go to IDLE.
  - Otherwise cnt+1.
  - Result: short_press fires DOUBLE_GAP_CYCLES edges after the release edge.
- PRESS2: !act -> double_press<=1, go to IDLE. No long-press timing in PRESS2; the second press may be of any length. cnt is held at 0.
- HOLD: waits for !act, then goes to IDLE with no pulse. Releasing after a long press never produces short_press.
- Boundaries:
  - A press lasting exactly L-1 edges after detection then released is short/double-eligible.
  - A press still active at the L-th edge is long.
  - A third press arriving after double_press starts a fresh sequence from IDLE.
  - cnt never exceeds max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES)-1; no wrap-around.
- ACTIVE_LEVEL=0 inverts act only; all timing is identical.

Test Plan (LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=4, ACTIVE_LEVEL=1):
- Reset: hold reset 3 cycles with line=1 -> all outputs 0. Release reset with line=1 -> pressed=1 next cycle; the sequence starts from IDLE.
- Short press: line=1 for 3 cycles, then 0 -> exactly one short_press pulse 4 cycles after release is sampled; long_press=0 and double_press=0 throughout.
- Long press: line=1 held for 20 cycles -> one long_press 8 cycles after detection. On release -> no short_press and no double_press within the next 10 cycles.
- Long/short threshold: press held 7 edges total after detection (cnt reaches 7 needs 8) -> short_press. Press held through the 8th edge -> long_press.
- Double press: 2 cycles high, 2 low, 5 high, then low -> double_press one cycle after the second release; no short_press.
- Gap expiry/race: line low for exactly 4 cycles after the first release, then high on the same edge cnt==3 -> PRESS2 (no short_press); release -> double_press. Separately: reset asserted during GAP -> no short_press ever.

Source files
------------

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into
// short / long / double press command pulses.
module button_event_decoder #(
    parameter logic        ACTIVE_LEVEL      = 1'b1,
    parameter int unsigned LONG_PRESS_CYCLES = 1000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_GAP,
        S_PRESS2,
        S_HOLD
    } state_e;

    localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(DOUBLE_GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pressed_q;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        dbl_q, dbl_d;
    logic        act;

    assign act = (line == ACTIVE_LEVEL);

    // Classification FSM: next state, counter and pulse requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (act) begin
                    state_d = S_PRESS1;
                    cnt_d   = '0;
                end
            end
            S_PRESS1: begin
                if (!act) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                // A new press beats gap expiry on the same edge.
                if (act) begin
                    state_d = S_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_PRESS2: begin
                cnt_d = '0;
                if (!act) begin
                    dbl_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                cnt_d = '0;
                if (!act) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, level and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= act;
            short_q   <= short_d;
            long_q    <= long_d;
            dbl_q     <= dbl_d;
        end
    end

    assign pressed      = pressed_q;
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = dbl_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (L=8, gap=4), checking
// an active-high and an active-low instance cycle by cycle.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic line = 1'b0;
    logic line_n;
    logic p_a, s_a, l_a, d_a;
    logic p_b, s_b, l_b, d_b;
    int   n_chk = 0;
    int   n_fail = 0;

    assign line_n = ~line;

    always #5 clk = ~clk;

    button_event_decoder #(
        .ACTIVE_LEVEL(1'b1),
        .LONG_PRESS_CYCLES(8),
        .DOUBLE_GAP_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .line(line),
        .pressed(p_a),
        .short_press(s_a),
        .long_press(l_a),
        .double_press(d_a)
    );

    button_event_decoder #(
        .ACTIVE_LEVEL(1'b0),
        .LONG_PRESS_CYCLES(8),
        .DOUBLE_GAP_CYCLES(4)
    ) dut_n (
        .clk(clk),
        .reset(reset),
        .line(line_n),
        .pressed(p_b),
        .short_press(s_b),
        .long_press(l_b),
        .double_press(d_b)
    );

    // exp = {pressed, short, long, double} after the edge
    task automatic tick(input logic l, input logic [3:0] exp,
                        input string tag);
        line = l;
        @(posedge clk);
        #1;
        n_chk++;
        assert ({p_a, s_a, l_a, d_a} === exp) else begin
            n_fail++;
            $error("FAIL %s hi: observed %b expected %b",
                   tag, {p_a, s_a, l_a, d_a}, exp);
        end
        n_chk++;
        assert ({p_b, s_b, l_b, d_b} === exp) else begin
            n_fail++;
            $error("FAIL %s lo: observed %b expected %b",
                   tag, {p_b, s_b, l_b, d_b}, exp);
        end
    endtask

    task automatic ticks(input int n, input logic l,
                         input logic [3:0] exp, input string tag);
        for (int i = 0; i < n; i++) tick(l, exp, tag);
    endtask

    initial begin
        // reset held with line pressed
        reset = 1'b1;
        ticks(3, 1'b1, 4'b0000, "rst");
        reset = 1'b0;
        // first edge out of reset detects the press
        tick(1'b1, 4'b1000, "rst_detect");
        tick(1'b0, 4'b0000, "rst_rel");
        ticks(3, 1'b0, 4'b0000, "rst_gap");
        tick(1'b0, 4'b0100, "rst_short");
        tick(1'b0, 4'b0000, "rst_idle");

        // short press, 3 cycles
        ticks(3, 1'b1, 4'b1000, "sp_hold");
        tick(1'b0, 4'b0000, "sp_rel");
        ticks(3, 1'b0, 4'b0000, "sp_gap");
        tick(1'b0, 4'b0100, "sp_pulse");
        ticks(2, 1'b0, 4'b0000, "sp_after");

        // long press, 20 cycles
        tick(1'b1, 4'b1000, "lp_detect");
        ticks(7, 1'b1, 4'b1000, "lp_count");
        tick(1'b1, 4'b1010, "lp_pulse");
        ticks(11, 1'b1, 4'b1000, "lp_hold");
        tick(1'b0, 4'b0000, "lp_rel");
        ticks(10, 1'b0, 4'b0000, "lp_quiet");

        // threshold: 7 edges after detection -> short
        tick(1'b1, 4'b1000, "th_s_detect");
        ticks(7, 1'b1, 4'b1000, "th_s_hold");
        tick(1'b0, 4'b0000, "th_s_rel");
        ticks(3, 1'b0, 4'b0000, "th_s_gap");
        tick(1'b0, 4'b0100, "th_s_pulse");
        tick(1'b0, 4'b0000, "th_s_after");

        // threshold: still pressed at 8th edge -> long
        tick(1'b1, 4'b1000, "th_l_detect");
        ticks(7, 1'b1, 4'b1000, "th_l_hold");
        tick(1'b1, 4'b1010, "th_l_pulse");
        tick(1'b0, 4'b0000, "th_l_rel");
        ticks(6, 1'b0, 4'b0000, "th_l_quiet");

        // double press: 2 high, 2 low, 5 high, low
        ticks(2, 1'b1, 4'b1000, "dp_p1");
        ticks(2, 1'b0, 4'b0000, "dp_gap");
        ticks(5, 1'b1, 4'b1000, "dp_p2");
        tick(1'b0, 4'b0001, "dp_pulse");
        ticks(5, 1'b0, 4'b0000, "dp_quiet");

        // third press starts a fresh sequence
        tick(1'b1, 4'b1000, "fr_detect");
        tick(1'b0, 4'b0000, "fr_rel");
        ticks(3, 1'b0, 4'b0000, "fr_gap");
        tick(1'b0, 4'b0100, "fr_short");
        tick(1'b0, 4'b0000, "fr_idle");

        // gap race: press arrives on the expiry edge
        tick(1'b1, 4'b1000, "rc_p1");
        ticks(4, 1'b0, 4'b0000, "rc_gap");
        tick(1'b1, 4'b1000, "rc_p2");
        tick(1'b0, 4'b0001, "rc_dbl");
        ticks(5, 1'b0, 4'b0000, "rc_quiet");

        // reset during gap discards the pending short press
        tick(1'b1, 4'b1000, "rg_p1");
        ticks(2, 1'b0, 4'b0000, "rg_gap");
        reset = 1'b1;
        tick(1'b0, 4'b0000, "rg_reset");
        reset = 1'b0;
        ticks(8, 1'b0, 4'b0000, "rg_quiet");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
